// File: rtl/d_cache_assoc.sv
// rtl/d_cache_assoc.sv - set-associative write-back data cache with burst flush/refill ports
module d_cache_assoc #(
    parameter int INDEX_WIDTH        = 4,
    parameter int BLOCK_OFFSET_WIDTH = 3,
    parameter int WAYS               = 2
) (
    input  logic        clk,
    input  logic        rst,
    // requester side
    input  logic        in_valid,
    input  logic        in_write,
    input  logic [3:0]  in_wstrb,
    input  logic [25:0] in_addr,
    input  logic [25:0] in_addr_next,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    // write-back burst channel
    output logic        awvalid,
    input  logic        awready,
    output logic [25:0] awaddr,
    output logic [3:0]  awlen,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    // refill burst channel
    output logic        arvalid,
    input  logic        arready,
    output logic [25:0] araddr,
    output logic [3:0]  arlen,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata
);

    localparam int LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH;
    localparam int DEPTH     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 24 - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int IDX_LO    = 2 + BLOCK_OFFSET_WIDTH;
    localparam int TAG_LO    = IDX_LO + INDEX_WIDTH;

    // Reject configurations the address split or the burst length field cannot express
    generate
        if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
            $error("d_cache_assoc: WAYS must be 1, 2 or 4");
        end
        if (BLOCK_OFFSET_WIDTH < 1 || BLOCK_OFFSET_WIDTH > 3) begin : g_bad_line
            $error("d_cache_assoc: line size must be 2..8 words");
        end
        if (TAG_WIDTH < 1) begin : g_bad_tag
            $error("d_cache_assoc: tag width must be positive");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_READY,
        S_FLUSH_REQ,
        S_FLUSH_DATA,
        S_REFILL_REQ,
        S_REFILL_DATA
    } state_t;

    state_t state, state_n;

    // request address fields
    logic [TAG_WIDTH-1:0]          req_tag;
    logic [INDEX_WIDTH-1:0]        req_idx;
    logic [BLOCK_OFFSET_WIDTH-1:0] req_off;
    logic [INDEX_WIDTH-1:0]        nxt_idx;

    assign req_tag = in_addr[25:TAG_LO];
    assign req_idx = in_addr[TAG_LO-1:IDX_LO];
    assign req_off = in_addr[IDX_LO-1:2];
    assign nxt_idx = in_addr_next[TAG_LO-1:IDX_LO];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{in_addr[1:0], in_addr_next[25:TAG_LO], in_addr_next[IDX_LO-1:0]};

    // line storage
    logic [TAG_WIDTH-1:0] tag_mem  [WAYS][DEPTH];
    logic [31:0]          data_mem [WAYS][DEPTH][LINE_SIZE];
    logic [DEPTH-1:0]     valid_q  [WAYS];
    logic [DEPTH-1:0]     dirty_q  [WAYS];
    logic [WAY_W-1:0]     rr_ptr   [DEPTH];

    // registered read index, loaded one cycle ahead from in_addr_next
    logic [INDEX_WIDTH-1:0] rd_idx;

    // miss context
    logic [TAG_WIDTH-1:0]          miss_tag;
    logic [INDEX_WIDTH-1:0]        miss_idx;
    logic [WAY_W-1:0]              vic_way;
    logic [BLOCK_OFFSET_WIDTH-1:0] beat;
    logic                          resp_pending;
    logic [31:0]                   fbuf [LINE_SIZE];

    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic             hit;
    logic [WAY_W-1:0] victim;
    logic             victim_dirty;
    logic             last_beat;
    logic             aw_fire;
    logic             w_fire;
    logic             ar_fire;
    logic             r_fire;
    logic             miss_start;

    // Tag compare across all ways of the pre-indexed set
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][rd_idx] && tag_mem[w][rd_idx] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        victim = rr_ptr[rd_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][rd_idx]) begin
                victim = WAY_W'(w);
            end
        end
    end

    assign victim_dirty = valid_q[victim][rd_idx] && dirty_q[victim][rd_idx];
    assign hit          = in_valid && (state == S_READY) && hit_any;
    assign miss_start   = in_valid && (state == S_READY) && !hit_any;
    assign out_valid    = hit;
    assign out_data     = data_mem[hit_way][rd_idx][req_off];

    assign last_beat = &beat;
    assign aw_fire   = awvalid && awready;
    assign w_fire    = wvalid && wready;
    assign ar_fire   = arvalid && arready;
    assign r_fire    = (state == S_REFILL_DATA) && rvalid;

    assign awaddr = {tag_mem[vic_way][miss_idx], miss_idx, {(BLOCK_OFFSET_WIDTH + 2){1'b0}}};
    assign araddr = {miss_tag, miss_idx, {(BLOCK_OFFSET_WIDTH + 2){1'b0}}};
    assign awlen  = 4'(LINE_SIZE);
    assign arlen  = 4'(LINE_SIZE);
    assign wdata  = fbuf[beat];
    assign wlast  = (state == S_FLUSH_DATA) && last_beat;
    assign bready = 1'b1;
    assign rready = 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_READY;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and bus valid generation
    always_comb begin
        state_n = state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        case (state)
            S_READY: begin
                if (miss_start) begin
                    state_n = victim_dirty ? S_FLUSH_REQ : S_REFILL_REQ;
                end
            end
            S_FLUSH_REQ: begin
                // a new burst waits until the previous write response has returned
                awvalid = !resp_pending;
                if (!resp_pending && awready) begin
                    state_n = S_FLUSH_DATA;
                end
            end
            S_FLUSH_DATA: begin
                wvalid = 1'b1;
                if (wready && last_beat) begin
                    state_n = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_n = S_REFILL_DATA;
                end
            end
            S_REFILL_DATA: begin
                if (rvalid && last_beat) begin
                    state_n = S_READY;
                end
            end
            default: state_n = S_READY;
        endcase
    end

    // Miss context, beat counter, outstanding-response flag and read index
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx       <= '0;
            miss_tag     <= '0;
            miss_idx     <= '0;
            vic_way      <= '0;
            beat         <= '0;
            resp_pending <= 1'b0;
        end else begin
            rd_idx <= nxt_idx;
            if (miss_start) begin
                miss_tag <= req_tag;
                miss_idx <= req_idx;
                vic_way  <= victim;
            end
            if (aw_fire) begin
                resp_pending <= 1'b1;
            end else if (bvalid) begin
                resp_pending <= 1'b0;
            end
            if (aw_fire || ar_fire) begin
                beat <= '0;
            end else if (w_fire || r_fire) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Snapshot of the victim line taken when the write burst is granted
    always_ff @(posedge clk) begin
        if (aw_fire) begin
            for (int k = 0; k < LINE_SIZE; k++) begin
                fbuf[k] <= data_mem[vic_way][miss_idx][k];
            end
        end
    end

    // Line arrays: store-hit byte writes, refill beats, and line install on the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                rr_ptr[i] <= '0;
            end
        end else begin
            if (hit && in_write && (in_wstrb != 4'b0000)) begin
                for (int b = 0; b < 4; b++) begin
                    if (in_wstrb[b]) begin
                        data_mem[hit_way][rd_idx][req_off][8*b +: 8] <= in_wdata[8*b +: 8];
                    end
                end
                dirty_q[hit_way][rd_idx] <= 1'b1;
            end
            if (r_fire) begin
                data_mem[vic_way][miss_idx][beat] <= rdata;
                if (last_beat) begin
                    tag_mem[vic_way][miss_idx] <= miss_tag;
                    valid_q[vic_way][miss_idx] <= 1'b1;
                    dirty_q[vic_way][miss_idx] <= 1'b0;
                    rr_ptr[miss_idx] <= (rr_ptr[miss_idx] == WAY_W'(WAYS - 1)) ?
                                        '0 : rr_ptr[miss_idx] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_d_cache_assoc.sv
// tb/tb_d_cache_assoc.sv - self-checking bench for d_cache_assoc with memory and cache models
module tb_d_cache_assoc;

    localparam int LINE  = 8;
    localparam int DEPTH = 16;
    localparam int WAYS  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_write = 1'b0;
    logic [3:0]  in_wstrb = 4'b0;
    logic [25:0] in_addr = '0;
    logic [25:0] in_addr_next = '0;
    logic [31:0] in_wdata = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [25:0] awaddr;
    logic [3:0]  awlen;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [31:0] wdata;
    logic        wlast;
    logic        bvalid = 1'b0;
    logic        bready;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [25:0] araddr;
    logic [3:0]  arlen;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    d_cache_assoc #(.INDEX_WIDTH(4), .BLOCK_OFFSET_WIDTH(3), .WAYS(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_write(in_write), .in_wstrb(in_wstrb),
        .in_addr(in_addr), .in_addr_next(in_addr_next), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_data(out_data),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // backing memory (what the bus slave holds) and architectural memory (what loads must see)
    logic [31:0] bmem [int];
    logic [31:0] arch [int];

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE0000 + 32'(a & 32'hFFFF);
    endfunction

    function automatic logic [31:0] brd(input int a);
        if (bmem.exists(a)) return bmem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] arch_rd(input int a);
        if (arch.exists(a)) return arch[a];
        return brd(a);
    endfunction

    // residency model: which tags live in which way of each set
    int m_tag   [DEPTH][WAYS];
    bit m_val   [DEPTH][WAYS];
    bit m_dirty [DEPTH][WAYS];
    int m_rr    [DEPTH];

    function automatic int idx_of(input int a); return (a >> 5) & 15; endfunction
    function automatic int tag_of(input int a); return a >> 9; endfunction

    function automatic int m_lookup(input int a);
        for (int w = 0; w < WAYS; w++)
            if (m_val[idx_of(a)][w] && m_tag[idx_of(a)][w] == tag_of(a)) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int i);
        for (int w = 0; w < WAYS; w++) if (!m_val[i][w]) return w;
        return m_rr[i];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_rr[i] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_val[i][w] = 0;
                m_dirty[i][w] = 0;
                m_tag[i][w] = 0;
            end
        end
        arch.delete();
    endtask

    // bus slave bookkeeping
    int ar_cnt = 0, aw_cnt = 0, r_beats = 0;
    int last_ar = -1, last_aw = -1;
    bit hold_b = 0;

    // Memory slave: drives handshakes on the falling edge, checks flush data against the model
    initial begin
        int r_act, r_beat, r_base, w_beat, w_base, b_pend, aw_wait;
        r_act = 0; r_beat = 0; r_base = 0; w_beat = 0; w_base = 0; b_pend = 0; aw_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                r_act = 0; b_pend = 0; aw_wait = 0;
                continue;
            end
            if (bvalid) bvalid = 0;
            else if (b_pend > 0 && !hold_b) begin
                bvalid = 1;
                b_pend--;
            end
            rvalid = 0;
            if (r_act != 0 && $urandom_range(0, 3) != 0) begin
                rvalid = 1;
                rdata = brd(r_base + 4 * r_beat);
                r_beat++;
                r_beats++;
                if (r_beat == LINE) r_act = 0;
            end
            arready = 0;
            if (arvalid && r_act == 0) begin
                arready = 1;
                chk("arlen", 32'(arlen), 32'd8);
                last_ar = int'(araddr);
                ar_cnt++;
                r_act = 1;
                r_beat = 0;
                r_base = int'(araddr);
            end
            wready = 0;
            if (wvalid) begin
                chk("flush_wdata", wdata, arch_rd(w_base + 4 * w_beat));
                chk("wlast_pos", 32'(wlast), 32'(w_beat == LINE - 1));
                if ($urandom_range(0, 2) != 0) begin
                    wready = 1;
                    bmem[w_base + 4 * w_beat] = wdata;
                    if (w_beat == LINE - 1) b_pend++;
                    w_beat++;
                end
            end
            awready = 0;
            if (awvalid) begin
                if (aw_wait < 1) aw_wait++;
                else begin
                    awready = 1;
                    aw_wait = 0;
                    chk("awlen", 32'(awlen), 32'd8);
                    last_aw = int'(awaddr);
                    aw_cnt++;
                    w_base = int'(awaddr);
                    w_beat = 0;
                end
            end
        end
    end

    // Load data compare on every cycle a load hit is reported
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && in_valid && !in_write && out_valid)
                chk("load_data", out_data, arch_rd(int'(in_addr)));
        end
    end

    task automatic access(input int a, input bit wr, input logic [3:0] strb,
                          input logic [31:0] wd, input bit exp_hit, output logic [31:0] dout);
        int mway, vic, ar0, aw0, rb0, n, i;
        bit exp_flush;
        logic [31:0] w;
        i = idx_of(a);
        @(posedge clk); #1;
        in_valid = 0;
        in_addr_next = 26'(a);
        @(posedge clk); #1;
        in_valid = 1; in_addr = 26'(a); in_write = wr; in_wstrb = strb; in_wdata = wd;
        mway = m_lookup(a);
        chk("model_hit_pin", 32'(mway >= 0), 32'(exp_hit));
        ar0 = ar_cnt; aw0 = aw_cnt; rb0 = r_beats;
        vic = 0; exp_flush = 0;
        if (mway < 0) begin
            vic = m_victim(i);
            exp_flush = m_val[i][vic] && m_dirty[i][vic];
        end
        @(negedge clk);
        chk("first_cycle_hit", 32'(out_valid), 32'(mway >= 0));
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("access_done", 32'(out_valid), 32'd1);
        if (mway < 0) begin
            chk("ar_count", 32'(ar_cnt - ar0), 32'd1);
            chk("aw_count", 32'(aw_cnt - aw0), 32'(exp_flush));
            chk("r_beats", 32'(r_beats - rb0), 32'd8);
            m_tag[i][vic] = tag_of(a);
            m_val[i][vic] = 1;
            m_dirty[i][vic] = 0;
            m_rr[i] = (m_rr[i] + 1) % WAYS;
            mway = vic;
        end
        dout = out_data;
        if (wr && strb != 4'b0) begin
            w = arch_rd(a);
            for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
            arch[a] = w;
            m_dirty[i][mway] = 1;
        end
        @(posedge clk); #1;
        in_valid = 0; in_write = 0; in_wstrb = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int rb0, n;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_awvalid", 32'(awvalid), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_wlast", 32'(wlast), 0);

        // cold load, then neighbouring word of the same line
        access(32'h040, 0, 4'b0, 0, 0, d);
        chk("cold_araddr", 32'(last_ar), 32'h040);
        access(32'h048, 0, 4'b0, 0, 1, d);
        chk("beat2_data", d, 32'hC0DE0048);

        // partial store and zero-strobe store
        bmem[32'h100] = 32'h11223344;
        access(32'h100, 0, 4'b0, 0, 0, d);
        chk("preload_data", d, 32'h11223344);
        access(32'h100, 1, 4'b0011, 32'hDEADBEEF, 1, d);
        access(32'h100, 1, 4'b0000, 32'hFFFFFFFF, 1, d);
        access(32'h100, 0, 4'b0, 0, 1, d);
        chk("strobe_merge", d, 32'h1122BEEF);

        // two tags in set 0, dirty way 0, third tag evicts way 0
        access(32'h000, 0, 4'b0, 0, 0, d);
        access(32'h200, 0, 4'b0, 0, 0, d);
        access(32'h004, 1, 4'b1111, 32'h55AA55AA, 1, d);
        access(32'h400, 0, 4'b0, 0, 0, d);
        chk("evict_awaddr", 32'(last_aw), 32'h000);
        chk("evict_araddr", 32'(last_ar), 32'h400);
        access(32'h200, 0, 4'b0, 0, 1, d);
        access(32'h004, 0, 4'b0, 0, 0, d);
        chk("flushed_word", d, 32'h55AA55AA);

        // dirty line holding the merged word gets written back
        access(32'h300, 0, 4'b0, 0, 0, d);
        access(32'h500, 0, 4'b0, 0, 0, d);
        chk("merge_awaddr", 32'(last_aw), 32'h100);

        // second dirty eviction must wait for the first write response
        hold_b = 1;
        access(32'h060, 0, 4'b0, 0, 0, d);
        access(32'h260, 0, 4'b0, 0, 0, d);
        access(32'h060, 1, 4'b1111, 32'h0BAD0060, 1, d);
        access(32'h260, 1, 4'b1111, 32'h0BAD0260, 1, d);
        access(32'h460, 0, 4'b0, 0, 0, d);
        fork
            access(32'h660, 0, 4'b0, 0, 0, d);
            begin
                repeat (3) @(negedge clk);
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    chk("aw_blocked", 32'(awvalid), 0);
                end
                hold_b = 0;
            end
        join
        chk("blocked_awaddr", 32'(last_aw), 32'h260);

        // reset in the middle of a refill
        @(posedge clk); #1;
        in_addr_next = 26'h0A0;
        @(posedge clk); #1;
        in_valid = 1; in_addr = 26'h0A0; in_write = 0;
        rb0 = r_beats;
        n = 0;
        while (r_beats < rb0 + 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("beats_before_rst", 32'(r_beats - rb0), 32'd3);
        #1 rst = 1;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_arvalid", 32'(arvalid), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_awvalid", 32'(awvalid), 0);
        chk("midrst_wvalid", 32'(wvalid), 0);
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        access(32'h0A0, 0, 4'b0, 0, 0, d);
        chk("post_rst_araddr", 32'(last_ar), 32'h0A0);
        access(32'h100, 0, 4'b0, 0, 0, d);
        chk("post_rst_backing", d, 32'h1122BEEF);
        access(32'h048, 0, 4'b0, 0, 0, d);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_cache_assoc.md
D_CACHE_ASSOC -- requirements
Module: d_cache_assoc

Interface
REQ-001 INDEX_WIDTH, 4, set-index bits (DEPTH = 2^INDEX_WIDTH sets).
REQ-002 BLOCK_OFFSET_WIDTH, 3, word-offset bits (LINE_SIZE = 2^BLOCK_OFFSET_WIDTH words, legal 2..8).
REQ-003 WAYS, 2, associativity (legal 1, 2, 4); illegal parameters SHALL fail elaboration.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  request present.
REQ-007 in_write  in  1  1 = store, 0 = load.
REQ-008 in_wstrb  in  4  store byte enables.
REQ-009 in_addr  in  26  registered byte address of the current request.
REQ-010 in_addr_next  in  26  next-cycle byte address, drives SRAM read index.
REQ-011 in_wdata  in  32  store data.
REQ-012 out_valid  out  1  hit; load data valid or store accepted.
REQ-013 out_data  out  32  load data.
REQ-014 awvalid/awready  out/in  1/1  write-address handshake.
REQ-015 awaddr  out  26  flush line address.
REQ-016 awlen  out  4  constant LINE_SIZE.
REQ-017 wvalid/wready  out/in  1/1  write-data handshake.
REQ-018 wdata  out  32  flush word.
REQ-019 wlast  out  1  last flush word.
REQ-020 bvalid/bready  in/out  1/1  write response; bready tied 1.
REQ-021 arvalid/arready  out/in  1/1  read-address handshake.
REQ-022 araddr  out  26  refill line address.
REQ-023 arlen  out  4  constant LINE_SIZE.
REQ-024 rvalid/rready/rdata  in/out/in  1/1/32  refill data; rready tied 1.

Function
REQ-025 Address split {tag, index, offset, 2'b00}; TAG_WIDTH = 24 - INDEX_WIDTH - BLOCK_OFFSET_WIDTH, SHALL be > 0.
REQ-026 Hit = in_valid & state READY & any way with valid bit set and stored tag == request tag; at most one way matches; out_valid = hit, combinational, zero added latency; out_data = hit way word[offset].
REQ-027 Tag and data SRAMs SHALL be read with the in_addr_next index so hit data is available in the request cycle.
REQ-028 Store hit: bytes with in_wstrb set written into hit way at cycle end; line dirty bit set; in_wstrb = 0 SHALL leave data and dirty bit unchanged.
REQ-029 Miss (in_valid & ~hit in READY): out_valid = 0; latch tag, index, victim way; victim = lowest-numbered invalid way, else rr_ptr[index].
REQ-030 FSM: READY -> FLUSH_REQ if victim valid & dirty, else REFILL_REQ; FLUSH_REQ -> FLUSH_DATA on awvalid & awready; FLUSH_DATA -> REFILL_REQ on wlast & wready; REFILL_REQ -> REFILL_DATA on arready; REFILL_DATA -> READY on last rvalid word.
REQ-031 FLUSH_REQ: awvalid held until awready, but SHALL NOT assert while a previous write response is outstanding (set on AW handshake, cleared on bvalid).
REQ-032 Flush: awaddr = {victim tag, index, 0}; victim line captured on AW handshake; words sent offset 0 upward, advancing only on wready; wlast on word LINE_SIZE-1.
REQ-033 Refill: araddr = {latched tag, index, 0}; word k written to victim way on k-th rvalid; on last word tag written, valid = 1, dirty = 0, rr_ptr[index] incremented mod WAYS.
REQ-034 Requester holds the request; it hits the cycle after returning to READY; in_valid = 0 SHALL cause no state change.
REQ-035 WAYS = 1 SHALL behave as a direct-mapped write-back cache.

Reset
REQ-036 rst in any state: next state READY; all valid, dirty, rr_ptr, pending-response and beat counters cleared; awvalid, wvalid, arvalid, wlast, out_valid 0 from the next cycle; in-flight bus transfer abandoned.

Verification
REQ-037 Cold load 0x000040 -> miss, araddr 0x000040, arlen 8, 8 beats, then out_valid 1 with beat-2 data for 0x000048.
REQ-038 Store 0xDEADBEEF strobe 4'b0011 to cached word holding 0x11223344 -> reload returns 0x1122BEEF, line dirty.
REQ-039 WAYS 2: fill two tags in set 0, dirty way 0, third tag same set -> way 0 flushed (8 W beats, wlast on 8th), refill into way 0, way 1 still hits.
REQ-040 Flush with bvalid withheld, then second dirty eviction -> awvalid stays 0 until bvalid.
REQ-041 rst asserted mid-REFILL_DATA after 3 beats -> READY, all lines invalid, arvalid 0; same load misses again.
